multiword_add_sequencer: RTL

//  Multi-cycle controller that computes an N-word add/subtract by sequencing one shared 16-bit CLA
//  (four 4-bit CLA blocks + LCU_4_to_16 carry unit) over NUM_WORDS cycles.

---
 rtl/multiword_add_sequencer_pkg.sv | 13 +
 rtl/multiword_add_sequencer_cla.sv | 58 +++++
 rtl/multiword_add_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// controller state encoding and the fixed width of one adder pass.
package multiword_add_sequencer_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multiword_add_sequencer_cla.sv
// 16-bit carry-lookahead adder: four 4-bit CLA groups whose group
// propagate/generate terms feed a 4-to-16 lookahead carry unit.
module multiword_add_sequencer_cla
   import multiword_add_sequencer_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   logic [WORD_W-1:0] p;
   logic [WORD_W-1:0] g;
   logic [WORD_W-1:0] bit_c;
   logic [3:0]        grp_p;
   logic [3:0]        grp_g;
   logic [4:0]        grp_c;

   assign p = a ^ b;
   assign g = a & b;

   // Each 4-bit group resolves its own internal carries from the group carry-in
   // and exports group propagate/generate for the lookahead unit.
   for (genvar i = 0; i < 4; i++) begin : g_grp
      logic [3:0] gp;
      logic [3:0] gg;
      logic       gc;

      assign gp = p[4*i +: 4];
      assign gg = g[4*i +: 4];
      assign gc = grp_c[i];

      assign bit_c[4*i]   = gc;
      assign bit_c[4*i+1] = gg[0] | (gp[0] & gc);
      assign bit_c[4*i+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc);
      assign bit_c[4*i+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                          | (gp[2] & gp[1] & gp[0] & gc);

      assign grp_p[i] = &gp;
      assign grp_g[i] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                      | (gp[3] & gp[2] & gp[1] & gg[0]);
   end

   // Lookahead carry unit: group carries computed in parallel from cin.
   assign grp_c[0] = cin;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
   assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

   assign sum  = p ^ bit_c;
   assign cout = grp_c[4];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built by running one shared 16-bit CLA over NUM_WORDS
// cycles, least-significant word first, with the carry held in a register.
module multiword_add_sequencer
   import multiword_add_sequencer_pkg::*;
#(
   parameter  int NUM_WORDS = 4,
   localparam int TOT_W     = WORD_W * NUM_WORDS
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             c_in,
   input  logic [TOT_W-1:0] op_a,
   input  logic [TOT_W-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [TOT_W-1:0] result,
   output logic             c_out,
   output logic             overflow
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t             state;
   logic [TOT_W-1:0]   a_reg;
   logic [TOT_W-1:0]   b_reg;
   logic               sub_reg;
   logic               carry_reg;
   logic [IDX_W-1:0]   idx;

   logic [WORD_W-1:0]  word_a;
   logic [WORD_W-1:0]  word_b_raw;
   logic [WORD_W-1:0]  word_b;
   logic [WORD_W-1:0]  word_sum;
   logic               word_cout;
   logic               accept;

   // Word select: subtraction feeds the inverted B word, the +1 comes from carry_reg.
   always_comb begin
      word_a     = a_reg[idx*WORD_W +: WORD_W];
      word_b_raw = b_reg[idx*WORD_W +: WORD_W];
      word_b     = sub_reg ? ~word_b_raw : word_b_raw;
      accept     = start && ((state == IDLE) || (state == DONE));
   end

   multiword_add_sequencer_cla u_cla (
      .a    (word_a),
      .b    (word_b),
      .cin  (carry_reg),
      .sum  (word_sum),
      .cout (word_cout)
   );

   // Controller, operand capture and per-word result write-back. A new start
   // is only taken in IDLE or DONE, which lets DONE chain straight into RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         c_out     <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         state     <= RUN;
         a_reg     <= op_a;
         b_reg     <= op_b;
         sub_reg   <= sub;
         carry_reg <= sub ? 1'b1 : c_in;
         idx       <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
            end
            RUN: begin
               result[idx*WORD_W +: WORD_W] <= word_sum;
               carry_reg <= word_cout;
               if (idx == LAST_IDX) begin
                  // Carry into the MSB is recovered from a^b^sum at that bit.
                  c_out    <= word_cout;
                  overflow <= (word_a[WORD_W-1] ^ word_b[WORD_W-1] ^ word_sum[WORD_W-1])
                              ^ word_cout;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
